// File: rtl/kypd_scan.sv
// kypd_scan: column-scanning driver and debounced decoder for a 4x4 matrix
// keypad. One column is pulled low per dwell period, the rows are sampled at
// the end of the dwell, and a whole-scan result must repeat DEBOUNCE_SCANS
// times before a key press or release is accepted.
module kypd_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key,
    output logic       o_key_valid,
    output logic       o_key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } resKind_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Map a scan position (column*4 + row) to the hex code printed on the key.
    function automatic logic [3:0] keyLut(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h4;
            4'd2:    code = 4'h7;
            4'd3:    code = 4'h0;
            4'd4:    code = 4'h2;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h8;
            4'd7:    code = 4'hF;
            4'd8:    code = 4'h3;
            4'd9:    code = 4'h6;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hE;
            4'd12:   code = 4'hA;
            4'd13:   code = 4'hB;
            4'd14:   code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]       r_rowMeta;
    logic [3:0]       r_rowSync;
    logic [DIV_W-1:0] r_divCnt;
    logic [1:0]       r_colIdx;
    logic [3:0]       r_col;
    logic [11:0]      r_pressMap;
    logic [CNT_W-1:0] r_stableCnt;
    logic [5:0]       r_prevResult;
    state_t           r_state;
    logic [3:0]       r_key;
    logic             r_keyValid;
    logic             r_keyHeld;

    logic             w_tick;
    logic             w_scanDone;
    logic [1:0]       w_nextColIdx;
    logic [15:0]      w_scanMap;
    logic [4:0]       w_pressCount;
    logic [3:0]       w_firstIdx;
    resKind_t         w_resKind;
    logic [3:0]       w_resCode;
    logic [5:0]       w_result;
    logic             w_match;
    logic [CNT_W-1:0] w_nextCnt;
    logic             w_stable;

    assign w_tick       = (r_divCnt == DIV_LAST);
    assign w_scanDone   = w_tick && (r_colIdx == 2'd3);
    assign w_nextColIdx = r_colIdx + 2'd1;

    // Column 3 is taken straight from the synchronizer on the scan-done tick.
    assign w_scanMap    = {~r_rowSync, r_pressMap};

    // Bring the asynchronous row lines into the clock domain; idle rows read high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rowMeta <= 4'hF;
            r_rowSync <= 4'hF;
        end else begin
            r_rowMeta <= i_row;
            r_rowSync <= r_rowMeta;
        end
    end

    // Dwell counter and column stepping; the column drive moves with the index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_divCnt <= '0;
            r_colIdx <= 2'd0;
            r_col    <= 4'b1110;
        end else if (w_tick) begin
            r_divCnt <= '0;
            r_colIdx <= w_nextColIdx;
            r_col    <= ~(4'b0001 << w_nextColIdx);
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    // Capture the pressed rows of columns 0..2 at the end of their dwell.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pressMap <= '0;
        end else if (w_tick && (r_colIdx != 2'd3)) begin
            r_pressMap[{r_colIdx, 2'b00} +: 4] <= ~r_rowSync;
        end
    end

    // Reduce the 16 sampled positions to NONE, one key code, or MULTI.
    always_comb begin
        w_pressCount = '0;
        w_firstIdx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_scanMap[i]) begin
                w_pressCount = w_pressCount + 5'd1;
                w_firstIdx   = 4'(i);
            end
        end
        w_resKind = RES_MULTI;
        w_resCode = 4'h0;
        if (w_pressCount == 5'd0) begin
            w_resKind = RES_NONE;
        end else if (w_pressCount == 5'd1) begin
            w_resKind = RES_SINGLE;
            w_resCode = keyLut(w_firstIdx);
        end
    end

    assign w_result  = {w_resKind, w_resCode};
    assign w_match   = (w_result == r_prevResult);
    assign w_nextCnt = !w_match ? CNT_W'(1) :
                       (r_stableCnt == CNT_MAX) ? CNT_MAX : r_stableCnt + 1'b1;
    assign w_stable  = (w_nextCnt == CNT_MAX);

    // Count how many consecutive scans produced the same result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stableCnt  <= '0;
            r_prevResult <= {RES_NONE, 4'h0};
        end else if (w_scanDone) begin
            r_stableCnt  <= w_nextCnt;
            r_prevResult <= w_result;
        end
    end

    // Accept a stable single key from IDLE; only a stable release returns to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_key      <= 4'h0;
            r_keyValid <= 1'b0;
            r_keyHeld  <= 1'b0;
        end else begin
            r_keyValid <= 1'b0;
            if (w_scanDone && w_stable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_resKind == RES_SINGLE) begin
                            r_state    <= ST_HELD;
                            r_key      <= w_resCode;
                            r_keyValid <= 1'b1;
                            r_keyHeld  <= 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (w_resKind == RES_NONE) begin
                            r_state   <= ST_IDLE;
                            r_keyHeld <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_keyHeld <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_col       = r_col;
    assign o_key       = r_key;
    assign o_key_valid = r_keyValid;
    assign o_key_held  = r_keyHeld;

endmodule

// File: tb/tb_kypd_scan.sv
// tb_kypd_scan: directed bench for kypd_scan with a small dwell and debounce
// so one full scan is 16 clocks. A keypad model pulls a row low whenever a
// pressed key's column is driven low.
module tb_kypd_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    // Key positions as bit index row*4 + column in pressMask.
    localparam int K1 = 0;
    localparam int K2 = 1;
    localparam int KA = 3;
    localparam int K5 = 5;
    localparam int K9 = 10;
    localparam int KE = 14;
    localparam int KD = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressMask = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulseCount = 0;
    int lastPulseCyc = -1;
    int doublePulses = 0;
    logic lastValid = 1'b0;

    kypd_scan #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_row(row),
        .o_col(col),
        .o_key(key),
        .o_key_valid(key_valid),
        .o_key_held(key_held)
    );

    always #5 clk = ~clk;

    // Matrix keypad: a row reads low if any pressed key on it sits in a driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressMask[r*4 +: 4] & ~col);
        end
    end

    // Step whole clocks, sampling on the falling edge and logging valid pulses.
    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (key_valid) begin
                pulseCount++;
                lastPulseCyc = cyc;
                if (lastValid) doublePulses++;
            end
            lastValid = key_valid;
        end
    endtask

    task automatic clearLog();
        cyc = 0;
        pulseCount = 0;
        lastPulseCyc = -1;
    endtask

    // Wait for the falling edge right after the column drive returns to column 0.
    task automatic waitScanStart();
        logic [3:0] prevCol;
        bit found;
        prevCol = col;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (prevCol == 4'b0111 && col == 4'b1110) found = 1;
            prevCol = col;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL scan_start_timeout: got no column wrap, required wrap within 64 cycles");
        end
    endtask

    task automatic test_reset();
        logic [3:0] expCol;
        rst_n = 1'b0;
        pressMask = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({col, key, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got col=%b key=%h v=%b h=%b, required col=1110 key=0 v=0 h=0",
                     col, key, key_valid, key_held);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            @(negedge clk);
            expCol = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            checks++;
            if ({col, key, key_valid, key_held} !== {expCol, 4'h0, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL scan_seq cycle %0d: got col=%b key=%h v=%b h=%b, required col=%b key=0 v=0 h=0",
                         k, col, key, key_valid, key_held, expCol);
            end
        end
    endtask

    task automatic test_single_press();
        waitScanStart();
        clearLog();
        pressMask[K5] = 1'b1;
        runCycles(96);
        checks++;
        if (pulseCount !== 1 || lastPulseCyc !== 48) begin
            errors++;
            $display("[TB] FAIL press5_pulse: got %0d pulses last at %0d, required 1 pulse at 48", pulseCount, lastPulseCyc);
        end
        checks++;
        if (key !== 4'h5 || key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL press5_key: got key=%h held=%b, required key=5 held=1", key, key_held);
        end
        pressMask = '0;
        runCycles(47);
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release5_early: got held=%b, required 1", key_held);
        end
        runCycles(1);
        checks++;
        if (key_held !== 1'b0 || key !== 4'h5 || pulseCount !== 1) begin
            errors++;
            $display("[TB] FAIL release5: got held=%b key=%h pulses=%0d, required held=0 key=5 pulses=1",
                     key_held, key, pulseCount);
        end
    endtask

    task automatic test_bounce();
        waitScanStart();
        clearLog();
        for (int k = 0; k < 50; k++) begin
            pressMask[K9] = ((k / 7) % 2 == 0);
            runCycles(1);
        end
        pressMask[K9] = 1'b1;
        runCycles(80);
        checks++;
        if (pulseCount !== 1 || lastPulseCyc !== 96) begin
            errors++;
            $display("[TB] FAIL bounce9_pulse: got %0d pulses last at %0d, required 1 pulse at 96", pulseCount, lastPulseCyc);
        end
        checks++;
        if (key !== 4'h9 || key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bounce9_key: got key=%h held=%b, required key=9 held=1", key, key_held);
        end
        pressMask = '0;
        runCycles(64);
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bounce9_release: got held=%b, required 0", key_held);
        end
    endtask

    task automatic test_two_keys();
        waitScanStart();
        clearLog();
        pressMask[K1] = 1'b1;
        pressMask[K2] = 1'b1;
        runCycles(80);
        checks++;
        if (pulseCount !== 0 || key_held !== 1'b0 || key !== 4'h9) begin
            errors++;
            $display("[TB] FAIL multi_idle: got pulses=%0d held=%b key=%h, required pulses=0 held=0 key=9",
                     pulseCount, key_held, key);
        end
        pressMask[K1] = 1'b0;
        runCycles(64);
        checks++;
        if (pulseCount !== 1 || lastPulseCyc !== 128 || key !== 4'h2) begin
            errors++;
            $display("[TB] FAIL multi_to_2: got pulses=%0d at %0d key=%h, required 1 pulse at 128 key=2",
                     pulseCount, lastPulseCyc, key);
        end
        pressMask = '0;
        runCycles(64);
    endtask

    task automatic test_no_rollover();
        waitScanStart();
        clearLog();
        pressMask[KA] = 1'b1;
        runCycles(64);
        checks++;
        if (pulseCount !== 1 || lastPulseCyc !== 48 || key !== 4'hA) begin
            errors++;
            $display("[TB] FAIL pressA: got pulses=%0d at %0d key=%h, required 1 pulse at 48 key=A",
                     pulseCount, lastPulseCyc, key);
        end
        pressMask[KD] = 1'b1;
        runCycles(64);
        pressMask[KA] = 1'b0;
        runCycles(64);
        checks++;
        if (pulseCount !== 1 || key !== 4'hA || key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rollover_D: got pulses=%0d key=%h held=%b, required pulses=1 key=A held=1",
                     pulseCount, key, key_held);
        end
        pressMask[KD] = 1'b0;
        runCycles(64);
        checks++;
        if (key_held !== 1'b0 || key !== 4'hA) begin
            errors++;
            $display("[TB] FAIL releaseD: got held=%b key=%h, required held=0 key=A", key_held, key);
        end
        pressMask[KD] = 1'b1;
        runCycles(64);
        checks++;
        if (pulseCount !== 2 || key !== 4'hD || key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL repressD: got pulses=%0d key=%h held=%b, required pulses=2 key=D held=1",
                     pulseCount, key, key_held);
        end
        pressMask = '0;
        runCycles(64);
    endtask

    task automatic test_reset_mid_hold();
        waitScanStart();
        clearLog();
        pressMask[KE] = 1'b1;
        runCycles(64);
        checks++;
        if (key !== 4'hE || key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pressE: got key=%h held=%b, required key=E held=1", key, key_held);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({col, key, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset: got col=%b key=%h v=%b h=%b, required col=1110 key=0 v=0 h=0",
                     col, key, key_valid, key_held);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clearLog();
        lastValid = 1'b0;
        runCycles(64);
        checks++;
        if (pulseCount !== 1 || lastPulseCyc !== 48 || key !== 4'hE || key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reaccept_E: got pulses=%0d at %0d key=%h held=%b, required 1 pulse at 48 key=E held=1",
                     pulseCount, lastPulseCyc, key, key_held);
        end
        pressMask = '0;
        runCycles(64);
    endtask

    task automatic test_back_to_back();
        checks++;
        if (doublePulses !== 0) begin
            errors++;
            $display("[TB] FAIL valid_back_to_back: got %0d double pulses, required 0", doublePulses);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_no_rollover();
        test_reset_mid_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
